add_share_arb: RTL and testbench
================================

Name: add_share_arb

Overview:
- Arbitrates one 32-bit carry-lookahead adder among NREQ requesters (IF PC+4, branch-target calc, LSB address calc, ALU) with round-robin fairness.
- Requests use valid/ready handshakes. Results are held in a single registered output slot, tagged with the one-hot owner.
- Replaces per-unit private adders in the core.

Parameters:
- NREQ, 4, number of requesters (2..8).
- XLEN, 32, operand and result width.

Ports:
- clk_in  input  1  core clock
- rst_n_in  input  1  asynchronous active-low reset
- rdy_in  input  1  global enable; low freezes all state
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  one-hot grant; a handshake occurs when valid&ready
- req_a  input  NREQ*XLEN  operand A; requester i uses slice [i*XLEN +: XLEN]
- req_b  input  NREQ*XLEN  operand B, same slicing
- req_sub  input  NREQ  1 = compute a-b, 0 = compute a+b
- resp_valid  output  NREQ  one-hot; result slot owned by requester i
- resp_ready  input  NREQ  requester i accepts the result
- resp_sum  output  XLEN  registered result
- resp_cout  output  1  registered carry-out (for sub: 1 = no borrow)
- resp_ovf  output  1  registered signed overflow

Behaviour:
- Reset (async, rst_n_in=0): resp_valid=0, resp_sum=0, resp_cout=0, resp_ovf=0, rr_ptr=0, slot empty. req_ready=0 throughout reset.
- The slot is free this cycle when it is empty, or when it is full and resp_ready[owner]=1 (drain and refill in the same cycle).
- Grant is combinational:
  - If rdy_in=1, the slot is free and any req_valid is set, req_ready is one-hot on the first valid index at or after rr_ptr, wrapping modulo NREQ.
  - Otherwise req_ready=0.
  - req_ready never asserts for a requester whose req_valid=0.
- Datapath: the adder core receives a, (sub ? ~b : b), cin=sub.
- Latency: the result is registered on the grant edge. resp_valid[i] rises the cycle after the handshake.
- The result holds stable (sum, cout, ovf, owner) until resp_ready[owner]=1 at a posedge.
- ovf = (a[XLEN-1] == b_eff[XLEN-1]) & (sum[XLEN-1] != a[XLEN-1]).
- rr_ptr: on a grant to index g, rr_ptr <= (g+1) mod NREQ. It is unchanged with no grant.
- Fairness: a requester holding valid is granted within NREQ grants.
- Drain without refill: resp_valid becomes 0 the next cycle; sum, cout and ovf keep their old values.
- The same requester may drain and re-request in one cycle; this is allowed if it wins arbitration.
- resp_ready bits of non-owners are ignored.
- rdy_in=0: no grants, no drain, all registers hold; resp_valid stays visible.
- Reset mid-operation: a pending result is discarded, with no response. Requesters must re-issue.
- Sum wraps modulo 2^XLEN; the carry is reported only in resp_cout.
- State machine, 2 states:
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on drain with no grant.
  - FULL -> FULL on drain+grant or no drain.

Decomposition:
- Shared package/header holds XLEN, NREQ_MAX=8, and the function rr_pick(valid, ptr) returning a one-hot vector.
- One sub-module, cla_add_core: combinational XLEN-bit CLA built from 4-bit/16-bit lookahead groups, with a carry-in and carry-out exposed.
- Arbitration, slot register and pointer live in add_share_arb.

Test Plan:
- Reset/single add:
  - Release reset.
  - req_valid=0001, a=0x0000_0004, b=0x0000_1000, sub=0.
  - Expect req_ready=0001 in the same cycle.
  - Next cycle: resp_valid=0001, sum=0x0000_1004, cout=0, ovf=0.
- Subtract/overflow:
  - Req 2, a=0x8000_0000, b=1, sub=1.
  - Expect sum=0x7FFF_FFFF, cout=1, ovf=1.
  - a=0, b=1, sub=1 -> sum=0xFFFF_FFFF, cout=0, ovf=0.
- Round-robin:
  - req_valid=1111 held, resp_ready=1111.
  - Expect grant sequence 0001, 0010, 0100, 1000, 0001.
  - One grant per cycle with back-to-back results, no bubbles.
- Backpressure:
  - Owner 1 has resp_ready=0 for 3 cycles while req_valid=0101.
  - Expect req_ready=0000 and resp_sum stable for those cycles.
  - On resp_ready[1]=1, the grant to index 2 (rr_ptr=2) occurs in the same cycle.
- rdy_in freeze:
  - Deassert rdy_in for 2 cycles with a pending result and valid requests.
  - Expect no grant, resp_valid held, rr_ptr unchanged.
  - Operation resumes identically afterwards.
- Async reset mid-flight:
  - Assert rst_n_in low between clock edges while resp_valid=0100.
  - Expect resp_valid=0, resp_sum=0 immediately.
  - After release, the first grant goes to index 0.

Source files
------------

// File: rtl/add_share_arb_pkg.sv
// Shared constants, slot FSM encodings and the round-robin picker used by the
// shared-adder arbiter.
package add_share_arb_pkg;

  localparam int XLEN     = 32;
  localparam int NREQ_MAX = 8;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // One-hot pick of the first valid index at or after ptr, wrapping at n (n <= NREQ_MAX).
  function automatic logic [NREQ_MAX-1:0] rr_pick(
    input logic [NREQ_MAX-1:0] valid,
    input logic [2:0]          ptr,
    input int                  n
  );
    logic [NREQ_MAX-1:0] pick;
    logic                found;
    int                  idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ_MAX; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && valid[idx[2:0]]) begin
        pick[idx[2:0]] = 1'b1;
        found          = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/add_share_arb_cla_add_core.sv
// Combinational carry-lookahead adder: 4-bit lookahead groups, 16-bit lookahead
// sections, sections chained by their group generate/propagate.
module cla_add_core #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            cin_i,
  output logic [XLEN-1:0] sum_o,
  output logic            cout_o
);

  localparam int W  = ((XLEN + 15) / 16) * 16;
  localparam int NG = W / 4;
  localparam int NS = W / 16;

  function automatic logic [3:0] la_carry(input logic [3:0] g, input logic [3:0] p, input logic c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  function automatic logic [1:0] la_gp(input logic [3:0] g, input logic [3:0] p);
    logic gg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

  logic [W-1:0]  a_w, b_w, g, p, c, sum_w;
  logic [NG-1:0] grp_g, grp_p, grp_c;
  logic [NS-1:0] sec_g, sec_p;
  logic [NS:0]   sec_c;

  // Zero padding up to a whole section keeps the carry into bit XLEN visible as a sum bit.
  generate
    if (W == XLEN) begin : g_nopad
      assign a_w = a_i;
      assign b_w = b_i;
    end else begin : g_pad
      assign a_w = {{(W-XLEN){1'b0}}, a_i};
      assign b_w = {{(W-XLEN){1'b0}}, b_i};
    end
  endgenerate

  assign g = a_w & b_w;
  assign p = a_w ^ b_w;

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
      assign {grp_g[gi], grp_p[gi]} = la_gp(g[4*gi +: 4], p[4*gi +: 4]);
      assign c[4*gi +: 4]           = la_carry(g[4*gi +: 4], p[4*gi +: 4], grp_c[gi]);
    end
    for (genvar gi = 0; gi < NS; gi++) begin : g_sec
      assign {sec_g[gi], sec_p[gi]} = la_gp(grp_g[4*gi +: 4], grp_p[4*gi +: 4]);
      assign grp_c[4*gi +: 4]       = la_carry(grp_g[4*gi +: 4], grp_p[4*gi +: 4], sec_c[gi]);
    end
  endgenerate

  always_comb begin
    sec_c    = '0;
    sec_c[0] = cin_i;
    for (int s = 0; s < NS; s++) begin
      sec_c[s+1] = sec_g[s] | (sec_p[s] & sec_c[s]);
    end
  end

  assign sum_w = p ^ c;
  assign sum_o = sum_w[XLEN-1:0];

  generate
    if (W == XLEN) begin : g_cout_sec
      assign cout_o = sec_c[NS];
    end else begin : g_cout_pad
      assign cout_o = sum_w[XLEN];
    end
  endgenerate

endmodule

// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one CLA adder among NREQ requesters, with a single
// registered result slot tagged by its one-hot owner.
module add_share_arb
  import add_share_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int XLEN = add_share_arb_pkg::XLEN
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ-1:0]      req_sub,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [XLEN-1:0]      resp_sum,
  output logic                 resp_cout,
  output logic                 resp_ovf
);

  logic [0:0]          state_q, state_d;
  logic [NREQ-1:0]     owner_q, owner_d;
  logic [XLEN-1:0]     sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d;

  logic [NREQ_MAX-1:0] valid_ext, pick;
  logic                drain, slot_free, grant_any;
  logic [NREQ-1:0]     grant;
  logic [2:0]          grant_idx;
  logic [XLEN-1:0]     op_a, op_b, b_eff, add_sum;
  logic                op_sub, add_cout;

  assign valid_ext = NREQ_MAX'(req_valid);
  assign pick      = rr_pick(valid_ext, rr_ptr_q, NREQ);

  assign drain     = rdy_in && (state_q == ST_FULL) && ((owner_q & resp_ready) != '0);
  assign slot_free = (state_q == ST_EMPTY) || drain;
  // Gating with rst_n_in keeps req_ready low for the whole reset, not just after the first edge.
  assign grant_any = rst_n_in && rdy_in && slot_free && (pick != '0);
  assign grant     = grant_any ? pick[NREQ-1:0] : '0;
  assign req_ready = grant;

  always_comb begin
    grant_idx = '0;
    op_a      = '0;
    op_b      = '0;
    op_sub    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_idx = 3'(i);
        op_a      = req_a[i*XLEN +: XLEN];
        op_b      = req_b[i*XLEN +: XLEN];
        op_sub    = req_sub[i];
      end
    end
  end

  assign b_eff = op_sub ? ~op_b : op_b;

  cla_add_core #(.XLEN(XLEN)) u_add (
    .a_i   (op_a),
    .b_i   (b_eff),
    .cin_i (op_sub),
    .sum_o (add_sum),
    .cout_o(add_cout)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      state_d  = ST_FULL;
      owner_d  = grant;
      sum_d    = add_sum;
      cout_d   = add_cout;
      ovf_d    = (op_a[XLEN-1] == b_eff[XLEN-1]) && (add_sum[XLEN-1] != op_a[XLEN-1]);
      rr_ptr_d = (grant_idx == 3'(NREQ-1)) ? 3'd0 : grant_idx + 3'd1;
    end else if (drain) begin
      // Result data stays put; only ownership is released.
      state_d = ST_EMPTY;
      owner_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_EMPTY;
      owner_q  <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign resp_valid = (state_q == ST_FULL) ? owner_q : '0;
  assign resp_sum   = sum_q;
  assign resp_cout  = cout_q;
  assign resp_ovf   = ovf_q;

endmodule

// File: tb/tb_add_share_arb.sv
// Scoreboard bench for add_share_arb: a reference grant/slot model predicts
// req_ready each cycle and queues expected results for the response checks.
module tb_add_share_arb;

  localparam int NREQ = 4;
  localparam int XLEN = 32;

  logic                 clk_in = 1'b0;
  logic                 rst_n_in, rdy_in;
  logic [NREQ-1:0]      req_valid, req_ready, req_sub, resp_valid, resp_ready;
  logic [NREQ*XLEN-1:0] req_a, req_b;
  logic [XLEN-1:0]      resp_sum;
  logic                 resp_cout, resp_ovf;

  always #5 clk_in = ~clk_in;

  add_share_arb #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .rdy_in    (rdy_in),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_sum  (resp_sum),
    .resp_cout (resp_cout),
    .resp_ovf  (resp_ovf)
  );

  typedef struct packed {
    logic [3:0]  owner;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t       exp_q[$];
  res_t       m_last;
  logic [1:0] m_ptr;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t model_add(input logic [3:0] owner, input logic [31:0] a,
                                     input logic [31:0] b, input logic sub);
    logic [32:0] full;
    logic [31:0] be;
    res_t        r;
    be      = sub ? ~b : b;
    full    = {1'b0, a} + {1'b0, be} + 33'(sub);
    r.owner = owner;
    r.sum   = full[31:0];
    r.cout  = full[32];
    r.ovf   = (a[31] == be[31]) && (full[31] != a[31]);
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ptr  = 2'd0;
    m_last = '0;
  endtask

  // One clock: check at the falling edge, update the model at the rising edge.
  task automatic cycle();
    logic [3:0] eg;
    logic       drain, full;
    int         idx;
    @(negedge clk_in);
    full  = (exp_q.size() != 0);
    eg    = '0;
    drain = full && rdy_in && ((exp_q[0].owner & resp_ready) != 4'd0);
    if (rdy_in && (!full || drain) && req_valid != 4'd0) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(m_ptr) + k) % NREQ;
        if (eg == 4'd0 && req_valid[idx]) eg[idx] = 1'b1;
      end
    end
    check_eq("grant", req_ready, eg);
    if (full) begin
      check_eq("rvalid", resp_valid, exp_q[0].owner);
      check_eq("rsum", resp_sum, exp_q[0].sum);
      check_eq("rflags", {resp_cout, resp_ovf}, {exp_q[0].cout, exp_q[0].ovf});
    end else begin
      check_eq("rvalid", resp_valid, 4'd0);
      check_eq("rsum", resp_sum, m_last.sum);
      check_eq("rflags", {resp_cout, resp_ovf}, {m_last.cout, m_last.ovf});
    end
    @(posedge clk_in);
    if (drain) m_last = exp_q.pop_front();
    for (int k = 0; k < NREQ; k++) begin
      if (eg[k]) begin
        exp_q.push_back(model_add(eg, req_a[k*XLEN +: XLEN], req_b[k*XLEN +: XLEN], req_sub[k]));
        m_ptr = 2'(k + 1);
      end
    end
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*XLEN +: XLEN] = $urandom;
      req_b[i*XLEN +: XLEN] = $urandom;
    end
    req_sub = 4'($urandom);
  endtask

  initial begin
    rst_n_in   = 1'b0;
    rdy_in     = 1'b1;
    req_valid  = 4'hF;
    resp_ready = 4'h0;
    req_a      = '0;
    req_b      = '0;
    req_sub    = '0;
    model_reset();

    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check_eq("rst_ready", req_ready, 4'd0);
    check_eq("rst_valid", resp_valid, 4'd0);
    check_eq("rst_sum", resp_sum, 32'd0);
    check_eq("rst_flags", {resp_cout, resp_ovf}, 2'b00);
    @(posedge clk_in);
    #1;
    rst_n_in  = 1'b1;
    req_valid = 4'h0;

    // Single add on requester 0
    req_valid        = 4'b0001;
    req_a[0 +: 32]   = 32'h0000_0004;
    req_b[0 +: 32]   = 32'h0000_1000;
    cycle();
    check_eq("add_valid", resp_valid, 4'b0001);
    check_eq("add_sum", resp_sum, 32'h0000_1004);
    check_eq("add_flags", {resp_cout, resp_ovf}, 2'b00);
    req_valid  = 4'h0;
    resp_ready = 4'hF;
    cycle();

    // Subtract with signed overflow, then a borrow (drain and refill together)
    req_valid       = 4'b0100;
    req_a[64 +: 32] = 32'h8000_0000;
    req_b[64 +: 32] = 32'h0000_0001;
    req_sub         = 4'b0100;
    cycle();
    check_eq("sub_ovf_sum", resp_sum, 32'h7FFF_FFFF);
    check_eq("sub_ovf_flags", {resp_cout, resp_ovf}, 2'b11);
    req_a[64 +: 32] = 32'h0000_0000;
    cycle();
    check_eq("sub_brw_valid", resp_valid, 4'b0100);
    check_eq("sub_brw_sum", resp_sum, 32'hFFFF_FFFF);
    check_eq("sub_brw_flags", {resp_cout, resp_ovf}, 2'b00);
    req_valid = 4'h0;
    cycle();

    // Round robin with everyone requesting and draining
    rand_ops();
    req_valid  = 4'hF;
    resp_ready = 4'hF;
    repeat (6) cycle();

    // Backpressure on owner 1
    req_valid = 4'h0;
    cycle();
    req_valid  = 4'b0010;
    resp_ready = 4'h0;
    cycle();
    req_valid = 4'b0101;
    repeat (3) cycle();
    resp_ready = 4'b0010;
    cycle();
    check_eq("bp_regrant", resp_valid, 4'b0100);

    // Freeze with a pending result and valid requests
    rdy_in     = 1'b0;
    req_valid  = 4'hF;
    resp_ready = 4'hF;
    repeat (2) cycle();
    rdy_in = 1'b1;
    repeat (3) cycle();

    // Random traffic
    repeat (300) begin
      rdy_in     = ($urandom_range(0, 7) != 0);
      req_valid  = 4'($urandom);
      resp_ready = 4'($urandom);
      rand_ops();
      cycle();
    end

    // Asynchronous reset while requester 2 owns the slot
    rdy_in     = 1'b1;
    req_valid  = 4'h0;
    resp_ready = 4'hF;
    cycle();
    req_valid  = 4'b0100;
    resp_ready = 4'h0;
    cycle();
    req_valid = 4'h0;
    #2;
    check_eq("pre_rst_valid", resp_valid, 4'b0100);
    rst_n_in = 1'b0;
    #1;
    check_eq("arst_valid", resp_valid, 4'd0);
    check_eq("arst_sum", resp_sum, 32'd0);
    check_eq("arst_flags", {resp_cout, resp_ovf}, 2'b00);
    check_eq("arst_ready", req_ready, 4'd0);
    model_reset();
    @(posedge clk_in);
    #2;
    rst_n_in  = 1'b1;
    req_valid = 4'hF;
    cycle();
    check_eq("post_rst_owner", resp_valid, 4'b0001);
    req_valid  = 4'h0;
    resp_ready = 4'hF;
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
